// File: rtl/popcount_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : popcount_seq_ctrl
//  Purpose  : Sequencer for a ternary neuron. One external 5-input popcount
//             unit is shared over the whole activation vector, one chunk per
//             cycle. The block accumulates popcount(x & w_pos) and then
//             subtracts popcount(x & w_neg). It compares the signed result
//             against a threshold.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n          clock (rising edge), asynchronous active-low reset
//    in_valid/in_ready   request handshake; in_ready is high only while idle
//    x, w_pos, w_neg     activation vector, +1 mask and -1 mask
//                        (5*N_CHUNKS bits each)
//    thr                 signed threshold (ACC_W bits)
//    pc_in / pc_out      operand to and result from the shared popcount unit
//    busy                high while chunks are being processed
//    out_valid/out_ready result handshake
//    out_sum             signed pos-minus-neg sum
//    out_fire            out_sum >= thr (signed compare)
// ============================================================================
module popcount_seq_ctrl #(
  parameter int N_CHUNKS = 5,
  parameter int ACC_W    = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5*N_CHUNKS-1:0] x,
  input  logic [5*N_CHUNKS-1:0] w_pos,
  input  logic [5*N_CHUNKS-1:0] w_neg,
  input  logic [ACC_W-1:0]      thr,
  output logic [4:0]            pc_in,
  input  logic [2:0]            pc_out,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_sum,
  output logic                  out_fire
);

  localparam int                 C_W     = 5 * N_CHUNKS;
  localparam int                 C_CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(N_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POS  = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [C_W-1:0]     r_x_cap;
  logic [C_W-1:0]     r_wpos_cap;
  logic [C_W-1:0]     r_wneg_cap;
  logic [ACC_W-1:0]   r_thr_cap;
  logic [C_CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_out_sum;
  logic               r_out_fire;
  logic               r_out_valid;

  logic [4:0]         w_pos_chunk [N_CHUNKS];
  logic [4:0]         w_neg_chunk [N_CHUNKS];
  logic [ACC_W-1:0]   w_pc_ext;
  logic               w_last;

  // Pre-masked chunks, selected by the chunk counter below.
  genvar gi;
  generate
    for (gi = 0; gi < N_CHUNKS; gi++) begin : g_chunk
      assign w_pos_chunk[gi] = r_x_cap[5*gi +: 5] & r_wpos_cap[5*gi +: 5];
      assign w_neg_chunk[gi] = r_x_cap[5*gi +: 5] & r_wneg_cap[5*gi +: 5];
    end
  endgenerate

  // pc_out is taken as-is. Approximate units may return 6 or 7, and those
  // values are accumulated without clamping.
  assign w_pc_ext = {{(ACC_W-3){1'b0}}, pc_out};
  assign w_last   = (r_cnt == C_LAST);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    pc_in       = 5'd0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_POS;
      end
      S_POS: begin
        busy  = 1'b1;
        pc_in = w_pos_chunk[r_cnt];
        if (w_last) w_state_nxt = S_NEG;
      end
      S_NEG: begin
        busy  = 1'b1;
        pc_in = w_neg_chunk[r_cnt];
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // The first DONE cycle only registers the result. The handshake
        // applies once out_valid is up.
        if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand capture, chunk counter, accumulator, result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_cap     <= '0;
      r_wpos_cap  <= '0;
      r_wneg_cap  <= '0;
      r_thr_cap   <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_sum   <= '0;
      r_out_fire  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x_cap    <= x;
            r_wpos_cap <= w_pos;
            r_wneg_cap <= w_neg;
            r_thr_cap  <= thr;
            r_cnt      <= '0;
            r_acc      <= '0;
          end
        end
        S_POS: begin
          r_acc <= r_acc + w_pc_ext;
          r_cnt <= w_last ? '0 : r_cnt + C_CNT_W'(1);
        end
        S_NEG: begin
          r_acc <= r_acc - w_pc_ext;
          r_cnt <= w_last ? '0 : r_cnt + C_CNT_W'(1);
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_sum   <= r_acc;
            r_out_fire  <= ($signed(r_acc) >= $signed(r_thr_cap));
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_fire  = r_out_fire;

endmodule
`default_nettype wire

// File: tb/tb_popcount_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_popcount_seq_ctrl
//  Purpose  : Directed self-checking bench for popcount_seq_ctrl. It provides
//             an exact popcount model or stubbed popcount results on pc_out.
//  Revision : 1.0  initial release
// ============================================================================
module tb_popcount_seq_ctrl;

  localparam int N_CHUNKS = 5;
  localparam int ACC_W    = 7;
  localparam int W        = 5 * N_CHUNKS;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [W-1:0]     x         = '0;
  logic [W-1:0]     w_pos     = '0;
  logic [W-1:0]     w_neg     = '0;
  logic [ACC_W-1:0] thr       = '0;
  logic             in_ready;
  logic             busy;
  logic             out_valid;
  logic             out_fire;
  logic [4:0]       pc_in;
  logic [2:0]       pc_out;
  logic [ACC_W-1:0] out_sum;

  int n_cmp = 0;
  int n_err = 0;

  // 0: exact popcount, 1: constant stub_val, 2: 7 during POS and 0 during NEG
  int         pc_mode  = 0;
  logic [2:0] stub_val = 3'd0;
  int         busy_cnt = 0;

  always #5 clk = ~clk;

  popcount_seq_ctrl #(.N_CHUNKS(N_CHUNKS), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w_pos     (w_pos),
    .w_neg     (w_neg),
    .thr       (thr),
    .pc_in     (pc_in),
    .pc_out    (pc_out),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_fire  (out_fire)
  );

  always_comb begin
    pc_out = 3'($countones(pc_in));
    if (pc_mode == 1)      pc_out = stub_val;
    else if (pc_mode == 2) pc_out = (busy_cnt < N_CHUNKS) ? 3'd7 : 3'd0;
  end

  // Tracks the busy cycles since the last accept, so the stub can tell POS
  // from NEG.
  always @(posedge clk) begin
    if (in_valid && in_ready) busy_cnt <= 0;
    else if (busy)            busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input string tag, input logic [W-1:0] xv, input logic [W-1:0] wp,
                       input logic [W-1:0] wn, input logic [ACC_W-1:0] tv);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    x = xv; w_pos = wp; w_neg = wn; thr = tv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles from accept edge until out_valid, counting busy cycles on the way.
  task automatic wait_done(input string tag, input logic chk_pc, output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bcyc++;
      if (chk_pc && lat < 5)       check({tag, "_pc_in_pos"}, 32'(pc_in), 32'h1F);
      else if (chk_pc && lat < 10) check({tag, "_pc_in_neg"}, 32'(pc_in), 32'h00);
      tick();
      lat++;
    end
    check({tag, "_done_seen"}, 32'(out_valid), 32'd1);
  endtask

  task automatic finish_txn(input string tag, input logic [ACC_W-1:0] es, input logic ef);
    check({tag, "_sum"},  32'(out_sum),  32'(es));
    check({tag, "_fire"}, 32'(out_fire), 32'(ef));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int bcyc;
    int seen;
    logic [ACC_W-1:0] hold_sum;
    logic             hold_fire;

    // ---- reset state ----
    #3;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_pc_in",     32'(pc_in),     32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_fire",  32'(out_fire),  32'd0);
    #10 rst_n = 1'b1;
    tick();

    // ---- exact model, all ones positive: 25, thr 20 -> fire ----
    pc_mode = 0;
    start("t1", 25'h1FFFFFF, 25'h1FFFFFF, 25'h0, 7'd20);
    wait_done("t1", 1'b1, lat, bcyc);
    check("t1_latency", 32'(lat),  32'd11);
    check("t1_busy",    32'(bcyc), 32'd10);
    finish_txn("t1", 7'd25, 1'b1);

    // ---- all ones negative: -25 (7'h67); thr -25 fires, thr -24 does not ----
    start("t2", 25'h1FFFFFF, 25'h0, 25'h1FFFFFF, 7'h67);
    wait_done("t2", 1'b0, lat, bcyc);
    check("t2_latency", 32'(lat), 32'd11);
    finish_txn("t2", 7'h67, 1'b1);
    start("t3", 25'h1FFFFFF, 25'h0, 25'h1FFFFFF, 7'h68);
    wait_done("t3", 1'b0, lat, bcyc);
    finish_txn("t3", 7'h67, 1'b0);

    // ---- stub constant 2: 10 - 10 = 0, thr 0 -> fire ----
    pc_mode = 1; stub_val = 3'd2;
    start("t4", 25'h0ABCDEF, 25'h1234567, 25'h0FEDCBA, 7'd0);
    wait_done("t4", 1'b0, lat, bcyc);
    finish_txn("t4", 7'd0, 1'b1);

    // ---- stub constant 7 (no clamping): 35 - 35 = 0 ----
    stub_val = 3'd7;
    start("t5", 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF, 7'd1);
    wait_done("t5", 1'b0, lat, bcyc);
    finish_txn("t5", 7'd0, 1'b0);

    // ---- stub 7 in POS only: 35, thr 35 -> fire ----
    pc_mode = 2;
    start("t6", 25'h0, 25'h0, 25'h0, 7'd35);
    wait_done("t6", 1'b0, lat, bcyc);
    finish_txn("t6", 7'd35, 1'b1);

    // ---- backpressure: 5 cycles with out_ready low while inputs churn ----
    pc_mode = 0;
    start("t7", 25'h00000FF, 25'h00000F0, 25'h000000F, 7'd1);
    wait_done("t7", 1'b0, lat, bcyc);
    // pos = 4, neg = 4 -> 0; 0 >= 1 is false
    hold_sum  = 7'd0;
    hold_fire = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      x        = x ^ 25'h1FFFFFF;
      thr      = thr + 7'd13;
      tick();
      check("t7_bp_sum",       32'(out_sum),   32'(hold_sum));
      check("t7_bp_fire",      32'(out_fire),  32'(hold_fire));
      check("t7_bp_in_ready",  32'(in_ready),  32'd0);
      check("t7_bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    finish_txn("t7", hold_sum, hold_fire);

    // ---- reset during NEG chunk 2, checked before any clock edge ----
    start("t8", 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF, 7'd0);
    for (int i = 0; i < 7; i++) tick();
    check("t8_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t8_async_in_ready",  32'(in_ready),  32'd1);
    check("t8_async_busy",      32'(busy),      32'd0);
    check("t8_async_pc_in",     32'(pc_in),     32'd0);
    check("t8_async_out_valid", 32'(out_valid), 32'd0);
    tick();
    tick();
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("t8_no_out_valid", 32'(seen), 32'd0);

    // ---- first transaction after reset: 0x155 & 0x3FF -> 3 + 2 = 5 ----
    start("t9", 25'h0000155, 25'h00003FF, 25'h0, 7'd5);
    wait_done("t9", 1'b0, lat, bcyc);
    check("t9_latency", 32'(lat), 32'd11);
    finish_txn("t9", 7'd5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/popcount_seq_ctrl.md
Name: popcount_seq_ctrl

Overview:
Sequencer for a ternary neuron that time-multiplexes one shared 5-input popcount unit (exact or approximate, instantiated outside this block) over a wide activation vector. Per transaction it computes popcount(x & w_pos) - popcount(x & w_neg) chunk by chunk and compares the signed sum against a threshold. It sits between the sensor-side input register and the neuron output stage, with valid/ready handshakes on both sides.

Parameters:
N_CHUNKS, 5, number of 5-bit chunks; input vector width W = 5*N_CHUNKS.
ACC_W, 7, signed accumulator/threshold width; must be >= clog2(7*N_CHUNKS+1)+1.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  transaction request.
in_ready  output  1  high only in IDLE.
x  input  W  binary activations.
w_pos  input  W  +1 weight mask.
w_neg  input  W  -1 weight mask.
thr  input  ACC_W  signed threshold.
pc_in  output  5  operand to shared popcount unit.
pc_out  input  3  unsigned result from popcount unit, combinational from pc_in.
busy  output  1  high in POS or NEG.
out_valid  output  1  result valid, high only in DONE.
out_ready  input  1  downstream accept.
out_sum  output  ACC_W  signed pos minus neg sum.
out_fire  output  1  out_sum >= thr, signed compare.

Behaviour:
- Reset (async, any state): state=IDLE, chunk counter=0, accumulator=0, captured operands=0; outputs in_ready=1, busy=0, out_valid=0, out_sum=0, out_fire=0, pc_in=0.
- States: IDLE, POS, NEG, DONE.
- IDLE: in_ready=1. On in_valid at a clock edge, capture x, w_pos, w_neg, thr; clear accumulator and counter; go to POS.
- POS: per cycle, pc_in = x_cap[5i+4:5i] & wpos_cap[5i+4:5i], where i = counter. Add zero-extended pc_out to the accumulator at the edge. Increment the counter. After i = N_CHUNKS-1, reset the counter to 0 and go to NEG.
- NEG: same chunking with wneg_cap. Subtract pc_out. After the last chunk, go to DONE.
- Do not clamp pc_out to 5. Approximate units may return 6 or 7; accumulate the value as given. ACC_W sizing guarantees no overflow.
- DONE: out_valid=1. out_sum = accumulator. out_fire = ($signed(out_sum) >= $signed(thr_cap)). Both are registered and held stable until out_ready. On out_valid & out_ready, go to IDLE. in_ready rises the following cycle; there is no back-to-back accept.
- Latency: if the accept edge is T, out_valid is high after edge T + 2*N_CHUNKS + 1 (11 cycles for the default).
- pc_in = 0 in IDLE and DONE.
- in_valid is ignored outside IDLE. Input buses are sampled only at the accept edge, so changes after acceptance have no effect.
- Reset mid-transaction discards the transaction with no output. The first accept after reset release behaves normally.
- Counter width is max(1, clog2(N_CHUNKS)). The counter never exceeds N_CHUNKS-1.

Test Plan:
- Reset -> in_ready=1, out_valid=0, busy=0, pc_in=0, out_sum=0. Assert rst_n low mid-cycle -> outputs clear without a clock edge.
- Exact popcount model, x=25'h1FFFFFF, w_pos=25'h1FFFFFF, w_neg=0, thr=20 -> out_sum=25, out_fire=1. out_valid first high 11 cycles after the accept edge. busy high for exactly 10 cycles. pc_in=5'h1F in POS, 0 in NEG.
- Exact model, x=25'h1FFFFFF, w_pos=0, w_neg=25'h1FFFFFF -> out_sum=-25. With thr=-25: out_fire=1. With thr=-24: out_fire=0.
- Stub pc_out constant 3'b010, any x/masks, thr=0 -> out_sum=0, out_fire=1. Stub constant 3'b111 with w_neg all ones -> out_sum=0 (no clamping). Stub driving 7 only in POS -> out_sum=35.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid, x, and thr -> out_sum and out_fire stable, in_ready=0. Then raise out_ready -> IDLE next cycle, in_ready=1, and a new accept proceeds.
- Reset asserted during NEG chunk 2 -> no out_valid. After release, run x=25'h0000155, w_pos=25'h00003FF, w_neg=0 -> out_sum=5.
